// File: rtl/kbd_event_ctrl.sv
// PS/2 set-2 keyboard event decoder: drains the receiver queue through a valid/pop handshake,
// tracks the held key, filters typematic repeats and counts distinct presses.
module kbd_event_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_valid_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_overflow_i,
  output logic             rx_pop_o,
  input  logic             err_clr_i,
  output logic [7:0]       key_code_o,
  output logic             key_ext_o,
  output logic             key_held_o,
  output logic [CNT_W-1:0] press_count_o,
  output logic             make_pulse_o,
  output logic             break_pulse_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t           state_q;
  logic             gap_q;
  logic             rx_pop_q;
  logic [7:0]       key_code_q;
  logic             key_ext_q;
  logic             key_held_q;
  logic [CNT_W-1:0] press_count_q;
  logic             make_pulse_q;
  logic             break_pulse_q;
  logic             err_q;

  logic consume_d;
  logic is_e0_d;
  logic is_f0_d;
  logic same_code_d;

  // gap masks the stale head byte during the cycle the receiver is still advancing
  assign consume_d   = rx_valid_i && !gap_q;
  assign is_e0_d     = (rx_data_i == 8'hE0);
  assign is_f0_d     = (rx_data_i == 8'hF0);
  assign same_code_d = key_held_q && (key_code_q == rx_data_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      gap_q         <= 1'b0;
      rx_pop_q      <= 1'b0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_held_q    <= 1'b0;
      press_count_q <= '0;
      make_pulse_q  <= 1'b0;
      break_pulse_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      rx_pop_q      <= 1'b0;
      gap_q         <= 1'b0;
      make_pulse_q  <= 1'b0;
      break_pulse_q <= 1'b0;
      if (err_clr_i) begin
        err_q <= 1'b0;
      end

      // Overflow wins over any byte offered in the same cycle; that byte stays queued.
      if (rx_overflow_i) begin
        err_q      <= 1'b1;
        key_held_q <= 1'b0;
        state_q    <= S_IDLE;
      end else if (consume_d) begin
        rx_pop_q <= 1'b1;
        gap_q    <= 1'b1;
        unique case (state_q)
          S_IDLE: begin
            if (is_e0_d) begin
              state_q <= S_EXT;
            end else if (is_f0_d) begin
              state_q <= S_BRK;
            end else if (!(same_code_d && !key_ext_q)) begin
              key_code_q    <= rx_data_i;
              key_ext_q     <= 1'b0;
              key_held_q    <= 1'b1;
              press_count_q <= press_count_q + CNT_W'(1);
              make_pulse_q  <= 1'b1;
            end
          end
          S_EXT: begin
            if (is_f0_d) begin
              state_q <= S_EXT_BRK;
            end else if (!is_e0_d) begin
              state_q <= S_IDLE;
              if (!(same_code_d && key_ext_q)) begin
                key_code_q    <= rx_data_i;
                key_ext_q     <= 1'b1;
                key_held_q    <= 1'b1;
                press_count_q <= press_count_q + CNT_W'(1);
                make_pulse_q  <= 1'b1;
              end
            end
          end
          S_BRK, S_EXT_BRK: begin
            state_q <= S_IDLE;
            if (is_e0_d || is_f0_d) begin
              err_q <= 1'b1;
            end else if (same_code_d && (key_ext_q == (state_q == S_EXT_BRK))) begin
              key_held_q    <= 1'b0;
              break_pulse_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_pop_o      = rx_pop_q;
  assign key_code_o    = key_code_q;
  assign key_ext_o     = key_ext_q;
  assign key_held_o    = key_held_q;
  assign press_count_o = press_count_q;
  assign make_pulse_o  = make_pulse_q;
  assign break_pulse_o = break_pulse_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Directed bench for kbd_event_ctrl: a queue models the PS/2 receiver and advances on rx_pop.
module tb_kbd_event_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_overflow = 1'b0;
  logic       err_clr = 1'b0;
  logic       rx_pop;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_held;
  logic [7:0] press_count;
  logic       make_pulse;
  logic       break_pulse;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  q[$];
  logic        pend_pop = 1'b0;
  logic [31:0] pop_hist = '0;
  int          pop_cnt = 0;
  int          make_cnt = 0;
  int          brk_cnt = 0;
  logic        both_seen = 1'b0;

  kbd_event_ctrl #(.CNT_W(8)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rx_valid_i    (rx_valid),
    .rx_data_i     (rx_data),
    .rx_overflow_i (rx_overflow),
    .rx_pop_o      (rx_pop),
    .err_clr_i     (err_clr),
    .key_code_o    (key_code),
    .key_ext_o     (key_ext),
    .key_held_o    (key_held),
    .press_count_o (press_count),
    .make_pulse_o  (make_pulse),
    .break_pulse_o (break_pulse),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic drive_rx();
    rx_valid = (q.size() != 0);
    rx_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // One clock; the receiver advances at the edge following a cycle with rx_pop high.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (pend_pop && q.size() != 0) q.delete(0);
    pend_pop = rx_pop;
    pop_hist = {pop_hist[30:0], rx_pop};
    if (rx_pop) pop_cnt++;
    if (make_pulse) make_cnt++;
    if (break_pulse) brk_cnt++;
    if (make_pulse && break_pulse) both_seen = 1'b1;
    drive_rx();
  endtask

  task automatic run_idle(input string tag);
    int n = 0;
    pop_cnt  = 0;
    make_cnt = 0;
    brk_cnt  = 0;
    pop_hist = '0;
    drive_rx();
    do begin
      cycle();
      n++;
    end while (!(q.size() == 0 && !pend_pop) && n < 2000);
    n_cmp++;
    if (n >= 2000) begin
      $display("FAIL %s_drain: queue left=%0d, required 0 within 2000 cycles", tag, q.size());
      n_bad++;
      q.delete();
      pend_pop = 1'b0;
      drive_rx();
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({rx_pop, key_code, key_ext, key_held, press_count, make_pulse, break_pulse, err} !== 22'h0) begin
      $display("FAIL reset_outputs: got pop=%b code=%h ext=%b held=%b cnt=%h mk=%b br=%b err=%b, required all 0",
               rx_pop, key_code, key_ext, key_held, press_count, make_pulse, break_pulse, err);
      n_bad++;
    end
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    n_cmp++;
    if ({rx_pop, key_held, press_count, err} !== 11'h0) begin
      $display("FAIL reset_release: got pop=%b held=%b cnt=%h err=%b, required 0", rx_pop, key_held, press_count, err);
      n_bad++;
    end
    $display("reset: cnt=%h held=%b err=%b", press_count, key_held, err);
  endtask

  task automatic test_make();
    q.push_back(8'h1C);
    run_idle("make");
    n_cmp++;
    if (key_code !== 8'h1C || key_ext !== 1'b0 || key_held !== 1'b1) begin
      $display("FAIL make_key: got code=%h ext=%b held=%b, required 1c 0 1", key_code, key_ext, key_held);
      n_bad++;
    end
    n_cmp++;
    if (press_count !== 8'h01) begin
      $display("FAIL make_count: got %h, required 01", press_count);
      n_bad++;
    end
    n_cmp++;
    if (make_cnt !== 1 || pop_cnt !== 1 || brk_cnt !== 0) begin
      $display("FAIL make_pulses: got make=%0d pop=%0d brk=%0d, required 1 1 0", make_cnt, pop_cnt, brk_cnt);
      n_bad++;
    end
    $display("make 1C: code=%h held=%b cnt=%h", key_code, key_held, press_count);
  endtask

  task automatic test_break();
    q.push_back(8'hF0);
    q.push_back(8'h1C);
    run_idle("break");
    n_cmp++;
    if (key_held !== 1'b0 || key_code !== 8'h1C || press_count !== 8'h01) begin
      $display("FAIL break_key: got held=%b code=%h cnt=%h, required 0 1c 01", key_held, key_code, press_count);
      n_bad++;
    end
    n_cmp++;
    if (brk_cnt !== 1 || pop_cnt !== 2 || make_cnt !== 0) begin
      $display("FAIL break_pulses: got brk=%0d pop=%0d make=%0d, required 1 2 0", brk_cnt, pop_cnt, make_cnt);
      n_bad++;
    end
    $display("break 1C: code=%h held=%b cnt=%h", key_code, key_held, press_count);
  endtask

  task automatic test_back_to_back();
    q.push_back(8'h1B);
    q.push_back(8'h1B);
    q.push_back(8'h1B);
    q.push_back(8'hF0);
    q.push_back(8'h1B);
    run_idle("b2b");
    n_cmp++;
    if (press_count !== 8'h02 || make_cnt !== 1 || brk_cnt !== 1) begin
      $display("FAIL b2b_typematic: got cnt=%h make=%0d brk=%0d, required 02 1 1", press_count, make_cnt, brk_cnt);
      n_bad++;
    end
    n_cmp++;
    if (pop_hist[9:0] !== 10'b1010101010 || pop_cnt !== 5) begin
      $display("FAIL b2b_pop_pattern: got %b (%0d pops), required 1010101010 (5 pops)", pop_hist[9:0], pop_cnt);
      n_bad++;
    end
    n_cmp++;
    if (key_held !== 1'b0 || key_code !== 8'h1B) begin
      $display("FAIL b2b_key: got held=%b code=%h, required 0 1b", key_held, key_code);
      n_bad++;
    end
    $display("b2b 1B x3 F0 1B: cnt=%h pops=%b", press_count, pop_hist[9:0]);
  endtask

  task automatic test_extended();
    q.push_back(8'hE0);
    q.push_back(8'h75);
    run_idle("ext_make");
    n_cmp++;
    if (key_code !== 8'h75 || key_ext !== 1'b1 || key_held !== 1'b1 || press_count !== 8'h03) begin
      $display("FAIL ext_make: got code=%h ext=%b held=%b cnt=%h, required 75 1 1 03",
               key_code, key_ext, key_held, press_count);
      n_bad++;
    end
    q.push_back(8'hF0);
    q.push_back(8'h75);
    run_idle("plain_brk");
    n_cmp++;
    if (key_held !== 1'b1 || brk_cnt !== 0 || err !== 1'b0) begin
      $display("FAIL ext_plain_break_ignored: got held=%b brk=%0d err=%b, required 1 0 0", key_held, brk_cnt, err);
      n_bad++;
    end
    q.push_back(8'hE0);
    q.push_back(8'hF0);
    q.push_back(8'h75);
    run_idle("ext_brk");
    n_cmp++;
    if (key_held !== 1'b0 || brk_cnt !== 1 || key_code !== 8'h75 || key_ext !== 1'b1 || pop_cnt !== 3) begin
      $display("FAIL ext_break: got held=%b brk=%0d code=%h ext=%b pops=%0d, required 0 1 75 1 3",
               key_held, brk_cnt, key_code, key_ext, pop_cnt);
      n_bad++;
    end
    $display("ext 75: code=%h ext=%b held=%b cnt=%h", key_code, key_ext, key_held, press_count);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 252; i++) q.push_back((i % 2) ? 8'h1B : 8'h1C);
    run_idle("wrap_fill");
    n_cmp++;
    if (press_count !== 8'hFF || make_cnt !== 252) begin
      $display("FAIL wrap_ff: got cnt=%h make=%0d, required ff 252", press_count, make_cnt);
      n_bad++;
    end
    q.push_back(8'h1C);
    run_idle("wrap_roll");
    n_cmp++;
    if (press_count !== 8'h00 || make_cnt !== 1 || key_code !== 8'h1C) begin
      $display("FAIL wrap_zero: got cnt=%h make=%0d code=%h, required 00 1 1c", press_count, make_cnt, key_code);
      n_bad++;
    end
    $display("wrap: cnt=%h code=%h", press_count, key_code);
  endtask

  task automatic test_framing();
    q.push_back(8'hF0);
    q.push_back(8'hF0);
    run_idle("frame");
    n_cmp++;
    if (err !== 1'b1 || key_held !== 1'b1 || key_code !== 8'h1C || brk_cnt !== 0) begin
      $display("FAIL frame_err: got err=%b held=%b code=%h brk=%0d, required 1 1 1c 0", err, key_held, key_code, brk_cnt);
      n_bad++;
    end
    // back in IDLE, so 1C is a typematic repeat rather than a release
    q.push_back(8'h1C);
    run_idle("frame_idle");
    n_cmp++;
    if (key_held !== 1'b1 || make_cnt !== 0 || brk_cnt !== 0 || press_count !== 8'h00) begin
      $display("FAIL frame_state_idle: got held=%b make=%0d brk=%0d cnt=%h, required 1 0 0 00",
               key_held, make_cnt, brk_cnt, press_count);
      n_bad++;
    end
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin
      $display("FAIL err_clr: got err=%b, required 0", err);
      n_bad++;
    end
    $display("framing F0 F0: err cleared to %b", err);
  endtask

  task automatic test_overflow();
    q.push_back(8'h1B);
    rx_overflow = 1'b1;
    drive_rx();
    cycle();
    rx_overflow = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || key_held !== 1'b0 || rx_pop !== 1'b0 || make_pulse !== 1'b0 || press_count !== 8'h00) begin
      $display("FAIL overflow: got err=%b held=%b pop=%b mk=%b cnt=%h, required 1 0 0 0 00",
               err, key_held, rx_pop, make_pulse, press_count);
      n_bad++;
    end
    run_idle("ovf_after");
    n_cmp++;
    if (key_code !== 8'h1B || key_held !== 1'b1 || press_count !== 8'h01 || pop_cnt !== 1) begin
      $display("FAIL overflow_byte_kept: got code=%h held=%b cnt=%h pops=%0d, required 1b 1 01 1",
               key_code, key_held, press_count, pop_cnt);
      n_bad++;
    end
    $display("overflow: err=%b code=%h cnt=%h", err, key_code, press_count);
  endtask

  task automatic test_reset_mid_prefix();
    q.push_back(8'hE0);
    run_idle("mid_e0");
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({key_held, press_count, err, make_pulse, break_pulse} !== 12'h0) begin
      $display("FAIL mid_reset_async: got held=%b cnt=%h err=%b mk=%b br=%b, required 0",
               key_held, press_count, err, make_pulse, break_pulse);
      n_bad++;
    end
    cycle();
    rst = 1'b0;
    q.push_back(8'h75);
    run_idle("mid_75");
    n_cmp++;
    if (key_code !== 8'h75 || key_ext !== 1'b0 || key_held !== 1'b1 || press_count !== 8'h01 || make_cnt !== 1) begin
      $display("FAIL mid_reset_decode: got code=%h ext=%b held=%b cnt=%h make=%0d, required 75 0 1 01 1",
               key_code, key_ext, key_held, press_count, make_cnt);
      n_bad++;
    end
    $display("reset after E0, then 75: code=%h ext=%b", key_code, key_ext);
  endtask

  task automatic test_pulse_exclusive();
    n_cmp++;
    if (both_seen !== 1'b0) begin
      $display("FAIL pulse_exclusive: got make&break together=%b, required 0", both_seen);
      n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_back_to_back();
    test_extended();
    test_wrap();
    test_framing();
    test_overflow();
    test_reset_mid_prefix();
    test_pulse_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kbd_event_ctrl.md
# kbd_event_ctrl

Keyboard event controller that sits between the PS/2 byte receiver and the display/ASCII path. It drains the receiver's scan-code queue one byte at a time using a valid/pop handshake and decodes PS/2 set-2 framing (E0 extended prefix, F0 break prefix). It tracks the currently held key, filters typematic repeats and counts distinct key presses. Its outputs drive the scan-code/ASCII seven-segment digits, their blanking and the press counter.

## Interface
- CNT_W, 8, width of press counter (wraps modulo 2^CNT_W)
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rx_valid  in  1  receiver queue non-empty; rx_data valid
- rx_data  in  8  scan-code byte at head of receiver queue
- rx_overflow  in  1  receiver queue overflowed (level)
- rx_pop  out  1  one-cycle pulse: head byte consumed, receiver advances
- err_clr  in  1  clears err sticky flag
- key_code  out  8  scan code of last make (held or last released)
- key_ext  out  1  key_code was E0-prefixed
- key_held  out  1  a key is currently pressed; used as segment enable for scan/ASCII digits
- press_count  out  CNT_W  number of new key presses
- make_pulse  out  1  one-cycle pulse on new press
- break_pulse  out  1  one-cycle pulse on release of held key
- err  out  1  sticky: overflow or framing error seen

## Operation
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- Consume condition: rx_valid=1 and gap=0. gap is a 1-cycle flag set on every consume; rx_valid is ignored while gap=1 (receiver updates after pop).
- On consume of byte b, registered updates at that edge: rx_pop=1 next cycle, gap=1, then per state:
  - IDLE: b=E0 -> EXT; b=F0 -> BRK; else MAKE(b,0), stay IDLE.
  - EXT: b=F0 -> EXT_BRK; b=E0 -> stay EXT; else MAKE(b,1) -> IDLE.
  - BRK: b=E0 or F0 -> framing error: err=1, -> IDLE, no key change; else BREAK(b,0) -> IDLE.
  - EXT_BRK: b=E0 or F0 -> framing error as above; else BREAK(b,1) -> IDLE.
- MAKE(b,e): if key_held=1 and key_code=b and key_ext=e -> typematic repeat, nothing changes. Otherwise key_code=b, key_ext=e, key_held=1, press_count+1 (wraps to 0 after 2^CNT_W-1), make_pulse=1.
- BREAK(b,e): if key_held=1 and key_code=b and key_ext=e -> key_held=0, break_pulse=1; key_code/key_ext retained. Otherwise ignored (no err).
- Overflow: rx_overflow=1 sampled on any edge -> err=1, key_held=0, state -> IDLE; any consume in the same cycle is discarded (no rx_pop). press_count unchanged.
- err_clr=1 clears err unless an error condition occurs in the same cycle (set wins).
- No rollover tracking: a MAKE of a different key while one is held replaces it (count increments).

## Timing
- Reset values: state IDLE, gap 0, rx_pop 0, key_code 00, key_ext 0, key_held 0, press_count 0, make_pulse 0, break_pulse 0, err 0.
- Latency: byte consumed at edge N -> rx_pop, key_*, press_count, pulses visible in cycle N+1.
- Throughput: max one byte per 2 cycles; back-to-back rx_valid yields rx_pop pattern 1,0,1,0.
- make_pulse/break_pulse/rx_pop high exactly one cycle; never make_pulse and break_pulse together.
- Reset asserted mid-prefix (EXT/BRK/EXT_BRK) returns to IDLE immediately; no pulse emitted; pending receiver byte consumed normally after reset release.
- All outputs registered; no combinational input-to-output paths.

## Test plan
- Reset, send 1C -> key_code=1C, key_ext=0, key_held=1, press_count=1, make_pulse one cycle, rx_pop one cycle.
- Then F0,1C -> key_held=0, key_code stays 1C, break_pulse one cycle, press_count=1, two rx_pop pulses.
- 1B,1B,1B,F0,1B -> press_count+1 only, one make_pulse, one break_pulse; bytes queued back-to-back give rx_pop every other cycle.
- E0,75 then E0,F0,75 -> key_code=75, key_ext=1, held then released; plain F0,75 while E0 75 held -> ignored, key_held stays 1.
- Press count wrap: 256 distinct-alternating makes (1C,1B,...) with CNT_W=8 -> press_count wraps FF->00; F0,F0 -> err=1, state IDLE; err_clr -> err=0.
- rx_overflow pulse while 1C held -> err=1, key_held=0, no rx_pop that cycle; reset asserted after E0 -> next byte 75 decoded as non-extended make.
